// File: rtl/demux12_buffered.sv
// demux12_buffered
//
// Registered 1-to-12 demultiplexer. Each word arriving on the input stream
// carries a destination index; the word is parked in that channel's holding
// slot until the channel's consumer acknowledges it. Illegal indices (12..15)
// are swallowed and reported with a one-cycle err pulse.
//
// Handshake semantics (both sides):
//   input : a word transfers at a rising edge when in_valid & in_ready.
//           in_ready is combinational and depends only on the addressed slot.
//           The producer holds in_data/in_sel steady while in_valid & ~in_ready.
//   output: slot i is offered while out_valid[i]; it is consumed at a rising
//           edge where out_ack[i] is high. out_ack[i] is ignored when
//           out_valid[i] is low.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   in_data     word to route (WIDTH bits)
//   in_sel      destination channel 0..11 (12..15 illegal)
//   in_valid    producer offers a word
//   in_ready    block accepts the word this cycle
//   out_data    12 slots, slot i at [i*WIDTH +: WIDTH]
//   out_valid   per-slot occupancy
//   out_ack     per-slot consumer acknowledge
//   count       number of occupied slots
//   err         one-cycle pulse after an illegal word was dropped
module demux12_buffered #(
  parameter int WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [3:0]            in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [12*WIDTH-1:0]   out_data,
  output logic [11:0]           out_valid,
  input  logic [11:0]           out_ack,
  output logic [3:0]            count,
  output logic                  err
);

  // Padded to 16 entries so any 4-bit in_sel indexes a defined bit.
  logic [15:0] valid_pad;
  logic [15:0] ack_pad;
  logic        sel_legal;
  logic        accept;
  logic [11:0] wr;
  logic [11:0] valid_nxt;
  logic [3:0]  count_nxt;
  logic        err_nxt;

  assign valid_pad = {4'b0000, out_valid};
  assign ack_pad   = {4'b0000, out_ack};
  assign sel_legal = (in_sel < 4'd12);

  // A slot being acked this cycle can be refilled in the same cycle.
  assign in_ready = sel_legal ? (~valid_pad[in_sel] | ack_pad[in_sel]) : 1'b1;
  assign accept   = in_valid & in_ready;

  always_comb begin
    wr        = '0;
    valid_nxt = '0;
    count_nxt = '0;
    err_nxt   = accept & ~sel_legal;
    for (int i = 0; i < 12; i++) begin
      wr[i] = accept & sel_legal & (in_sel == 4'(i));
    end
    // Write wins over a same-cycle ack on the same slot.
    valid_nxt = (out_valid & ~out_ack) | wr;
    for (int i = 0; i < 12; i++) begin
      count_nxt = count_nxt + {3'b000, valid_nxt[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= '0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      out_valid <= valid_nxt;
      count     <= count_nxt;
      err       <= err_nxt;
      for (int i = 0; i < 12; i++) begin
        if (wr[i]) begin
          out_data[i*WIDTH +: WIDTH] <= in_data;
        end
      end
    end
  end

endmodule
